// File: rtl/full_adder_s_pkg.sv
// Shared constants and golden model for the structural ripple adder.
package full_adder_s_pkg;

  localparam int FA_MAX_WIDTH = 64;

  function automatic logic [FA_MAX_WIDTH:0] fa_ref(
    input logic [FA_MAX_WIDTH-1:0] a,
    input logic [FA_MAX_WIDTH-1:0] b,
    input logic                    cin
  );
    logic [FA_MAX_WIDTH:0] r;
    r = {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, cin};
    return r;
  endfunction

endpackage

// File: rtl/full_adder_s_cell.sv
// One-bit full adder cell built only from gate primitives.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic ab;
  logic bc;
  logic ca;

  xor x_p  (p, a, b);
  xor x_s  (s, p, ci);
  and g_ab (ab, a, b);
  and g_bc (bc, b, ci);
  and g_ca (ca, ci, a);
  or  g_co (co, ab, bc, ca);

endmodule

// File: rtl/full_adder_s.sv
// Registered structural ripple-carry adder.
// Optional signed-overflow output enabled by FULL_ADDER_S_OVF_EN.
module full_adder_s
  import full_adder_s_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef FULL_ADDER_S_OVF_EN
  ,
  output logic             ovf
`endif
);

  generate
    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
      $error("full_adder_s: WIDTH out of range");
    end
  endgenerate

  logic [WIDTH:0]   c_w;
  logic [WIDTH-1:0] s_w;

  assign c_w[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c_w[i]),
      .s  (s_w[i]),
      .co (c_w[i+1])
    );
  end

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_d;
  logic             carry_q;

  always_comb begin
    sum_d   = s_w;
    carry_d = c_w[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;

`ifdef FULL_ADDER_S_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Sign overflow: carry into MSB differs from carry out of it.
  always_comb begin
    ovf_d = c_w[WIDTH] ^ c_w[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_s.sv
// Scoreboard bench for full_adder_s at WIDTH 1, 8 and 16.
// Checks ovf too when FULL_ADDER_S_OVF_EN is defined.
module tb_full_adder_s;
  import full_adder_s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r1 = 1'b0;
  logic        a1 = 1'b0;
  logic        b1 = 1'b0;
  logic        c1 = 1'b0;
  logic        s1;
  logic        co1;
  logic        r8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        c8 = 1'b0;
  logic [7:0]  s8;
  logic        co8;
  logic        r16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        c16 = 1'b0;
  logic [15:0] s16;
  logic        co16;
`ifdef FULL_ADDER_S_OVF_EN
  logic        o1;
  logic        o8;
  logic        o16;
`endif

  full_adder_s #(.WIDTH(1)) u_d1 (
    .clk   (clk),
    .rst_n (r1),
    .a     (a1),
    .b     (b1),
    .cin   (c1),
    .sum   (s1),
    .carry (co1)
`ifdef FULL_ADDER_S_OVF_EN
    ,
    .ovf   (o1)
`endif
  );

  full_adder_s #(.WIDTH(8)) u_d8 (
    .clk   (clk),
    .rst_n (r8),
    .a     (a8),
    .b     (b8),
    .cin   (c8),
    .sum   (s8),
    .carry (co8)
`ifdef FULL_ADDER_S_OVF_EN
    ,
    .ovf   (o8)
`endif
  );

  full_adder_s #(.WIDTH(16)) u_d16 (
    .clk   (clk),
    .rst_n (r16),
    .a     (a16),
    .b     (b16),
    .cin   (c16),
    .sum   (s16),
    .carry (co16)
`ifdef FULL_ADDER_S_OVF_EN
    ,
    .ovf   (o16)
`endif
  );

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected result for a w-bit add; zero when the edge is a reset edge.
  function automatic exp_t model(
    input int          w,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        ci,
    input logic        rst_n
  );
    exp_t                  e;
    logic [FA_MAX_WIDTH:0] r;
    logic [16:0]           mk;
    e = '0;
    if (!rst_n) return e;
    r   = fa_ref({48'b0, a}, {48'b0, b}, ci);
    mk  = (17'd1 << w) - 17'd1;
    e.s = r[15:0] & mk[15:0];
    e.c = r[w];
    e.o = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic test_reset_truth();
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if ({co1, s1} !== {e.c, e.s[0]}) begin
          failures++;
          $display("FAIL w1_truth step%0d got=%b%b exp=%b%b",
                   i, co1, s1, e.c, e.s[0]);
        end
`ifdef FULL_ADDER_S_OVF_EN
        checks++;
        if (o1 !== e.o) begin
          failures++;
          $display("FAIL w1_ovf step%0d got=%b exp=%b", i, o1, e.o);
        end
`endif
      end
      if (i < 10) begin
        if (i < 2) begin
          r1 = 1'b0;
          {a1, b1, c1} = 3'b111;
        end else begin
          r1 = 1'b1;
          {a1, b1, c1} = 3'(i - 2);
        end
        sb.push_back(model(1, {15'b0, a1}, {15'b0, b1}, c1, r1));
      end
    end
  endtask

  task automatic test_reset_same_edge();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if ({co1, s1} !== {e.c, e.s[0]}) begin
          failures++;
          $display("FAIL w1_rst_edge step%0d got=%b%b exp=%b%b",
                   i, co1, s1, e.c, e.s[0]);
        end
      end
      if (i < 2) begin
        r1 = (i == 1);
        {a1, b1, c1} = 3'b111;
        sb.push_back(model(1, {15'b0, a1}, {15'b0, b1}, c1, r1));
      end
    end
  endtask

  task automatic run8(input string nm, input logic [16:0] v[3],
                      input logic [2:0] ov);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if ({co8, s8} !== {e.c, e.s[7:0]}) begin
          failures++;
          $display("FAIL %s vec%0d got=%b/%h exp=%b/%h",
                   nm, i - 1, co8, s8, e.c, e.s[7:0]);
        end
`ifdef FULL_ADDER_S_OVF_EN
        checks++;
        if (o8 !== ov[i-1]) begin
          failures++;
          $display("FAIL %s_ovf vec%0d got=%b exp=%b",
                   nm, i - 1, o8, ov[i-1]);
        end
`endif
      end
      if (i < 3) begin
        r8 = 1'b1;
        {a8, b8, c8} = v[i];
        sb.push_back(model(8, {8'b0, a8}, {8'b0, b8}, c8, r8));
      end
    end
  endtask

  task automatic test_boundary();
    logic [16:0] v[3];
    v[0] = {8'hFF, 8'h01, 1'b0};
    v[1] = {8'hFF, 8'hFF, 1'b1};
    v[2] = {8'h00, 8'h00, 1'b0};
    run8("w8_bound", v, 3'b000);
    if (sb.size() != 0) $display("note: queue not drained");
  endtask

  task automatic test_back_to_back();
    logic [16:0] v[3];
    exp_t        e;
    v[0] = {8'h12, 8'h34, 1'b0};
    v[1] = {8'h80, 8'h80, 1'b0};
    v[2] = {8'h7F, 8'h00, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if ({co8, s8} !== {e.c, e.s[7:0]}) begin
          failures++;
          $display("FAIL w8_b2b vec%0d got=%b/%h exp=%b/%h",
                   i - 1, co8, s8, e.c, e.s[7:0]);
        end
      end
      if (i < 3) begin
        r8 = 1'b1;
        {a8, b8, c8} = v[i];
        case (i)
          0:       e = '{s: 16'h0046, c: 1'b0, o: 1'b0};
          1:       e = '{s: 16'h0000, c: 1'b1, o: 1'b1};
          default: e = '{s: 16'h0080, c: 1'b0, o: 1'b1};
        endcase
        sb.push_back(e);
      end
    end
  endtask

  task automatic test_ovf();
    logic [16:0] v[3];
    v[0] = {8'h7F, 8'h00, 1'b1};
    v[1] = {8'h80, 8'h80, 1'b0};
    v[2] = {8'h12, 8'h34, 1'b0};
    run8("w8_ovf", v, 3'b011);
  endtask

  task automatic test_random16();
    exp_t e;
    for (int i = 0; i < 1001; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if ({co16, s16} !== {e.c, e.s}) begin
          failures++;
          $display("FAIL w16_rand vec%0d got=%b/%h exp=%b/%h",
                   i - 1, co16, s16, e.c, e.s);
        end
`ifdef FULL_ADDER_S_OVF_EN
        checks++;
        if (o16 !== e.o) begin
          failures++;
          $display("FAIL w16_ovf vec%0d got=%b exp=%b",
                   i - 1, o16, e.o);
        end
`endif
      end
      if (i < 1000) begin
        r16 = (i != 500);
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        c16 = 1'($urandom);
        if (i == 10) begin
          a16 = 16'hFFFF;
          b16 = 16'hFFFF;
          c16 = 1'b1;
        end
        sb.push_back(model(16, a16, b16, c16, r16));
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset_truth();
    test_reset_same_edge();
    test_boundary();
    test_back_to_back();
    test_ovf();
    test_random16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
